// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, timing constants and the control bundle carried down the
// D/E/M/W pipeline of the five-stage MIPS core.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  typedef enum logic [1:0] {NPC_PC4, NPC_BEQ, NPC_J, NPC_JR} npc_op_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI} alu_op_t;
  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  } md_op_t;
  typedef enum logic [1:0] {WD_ALU, WD_DM, WD_PC8, WD_HILO} wd_sel_t;
  typedef enum logic [1:0] {FWD_GRF, FWD_E, FWD_M, FWD_W} fwd_t;

  typedef logic [1:0] time_t;
  localparam time_t TUSE_0    = 2'd0;
  localparam time_t TUSE_1    = 2'd1;
  localparam time_t TUSE_2    = 2'd2;
  localparam time_t TUSE_NONE = 2'd3;
  localparam time_t TNEW_0    = 2'd0;
  localparam time_t TNEW_1    = 2'd1;
  localparam time_t TNEW_2    = 2'd2;

  typedef struct packed {
    npc_op_t npc_op;
    logic    ext_op;
    alu_op_t alu_ctrl;
    logic    alub_sel;
    md_op_t  md_op;
    logic    md_use;     // touches HI/LO or the MDU: mult/div/mf/mt
    logic    mem_write;
    logic    mem_read;
    logic    reg_write;
    wd_sel_t wd_sel;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    time_t      tnew;
  } stage_t;

  localparam ctrl_t  CTRL_NOP  = '0;
  localparam stage_t STAGE_NOP = '0;

  function automatic time_t sat_dec(input time_t t);
    return (t == TNEW_0) ? TNEW_0 : time_t'(t - 2'd1);
  endfunction

  function automatic logic writes_src(input stage_t s, input logic [4:0] src);
    return (src != 5'd0) && (s.a3 == src) && s.ctrl.reg_write;
  endfunction

  function automatic logic fwd_ready(input stage_t s, input logic [4:0] src);
    return writes_src(s, src) && (s.tnew == TNEW_0);
  endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational D-stage decoder: instruction to control bundle, destination
// register, result-ready time (Tnew) and operand-need times (Tuse).
module instr_dec
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [4:0]  a3_o,
  output time_t       tnew_o,
  output time_t       tuse_rs_o,
  output time_t       tuse_rt_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = instr_i[31:26];
  assign fn           = instr_i[5:0];
  assign rt           = instr_i[20:16];
  assign rd           = instr_i[15:11];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    ctrl_o    = CTRL_NOP;
    a3_o      = '0;
    tnew_o    = TNEW_0;
    tuse_rs_o = TUSE_NONE;
    tuse_rt_o = TUSE_NONE;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            ctrl_o.alu_ctrl  = (fn == FN_SUBU) ? ALU_SUB : ALU_ADD;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wd_sel    = WD_ALU;
            a3_o             = rd;
            tnew_o           = TNEW_1;
            tuse_rs_o        = TUSE_1;
            tuse_rt_o        = TUSE_1;
          end
          FN_JR: begin
            ctrl_o.npc_op = NPC_JR;
            a3_o          = rd;
            tuse_rs_o     = TUSE_0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO: begin
            ctrl_o.md_use = 1'b1;
            a3_o          = rd;
            tuse_rs_o     = TUSE_1;
            if (fn != FN_MTHI && fn != FN_MTLO) tuse_rt_o = TUSE_1;
            case (fn)
              FN_MULT:  ctrl_o.md_op = MD_MULT;
              FN_MULTU: ctrl_o.md_op = MD_MULTU;
              FN_DIV:   ctrl_o.md_op = MD_DIV;
              FN_DIVU:  ctrl_o.md_op = MD_DIVU;
              FN_MTHI:  ctrl_o.md_op = MD_MTHI;
              default:  ctrl_o.md_op = MD_MTLO;
            endcase
          end
          FN_MFHI, FN_MFLO: begin
            ctrl_o.md_use    = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wd_sel    = WD_HILO;
            a3_o             = rd;
            tnew_o           = TNEW_1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        ctrl_o.alu_ctrl  = ALU_OR;
        ctrl_o.alub_sel  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        a3_o             = rt;
        tnew_o           = TNEW_1;
        tuse_rs_o        = TUSE_1;
      end
      OP_LUI: begin
        ctrl_o.alu_ctrl  = ALU_LUI;
        ctrl_o.alub_sel  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        a3_o             = rt;
        tnew_o           = TNEW_1;
      end
      OP_LW: begin
        ctrl_o.alu_ctrl  = ALU_ADD;
        ctrl_o.alub_sel  = 1'b1;
        ctrl_o.ext_op    = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.wd_sel    = WD_DM;
        a3_o             = rt;
        tnew_o           = TNEW_2;
        tuse_rs_o        = TUSE_1;
      end
      OP_SW: begin
        ctrl_o.alu_ctrl  = ALU_ADD;
        ctrl_o.alub_sel  = 1'b1;
        ctrl_o.ext_op    = 1'b1;
        ctrl_o.mem_write = 1'b1;
        a3_o             = rt;
        tuse_rs_o        = TUSE_1;
        tuse_rt_o        = TUSE_2;
      end
      OP_BEQ: begin
        ctrl_o.npc_op = NPC_BEQ;
        ctrl_o.ext_op = 1'b1;
        a3_o          = rt;
        tuse_rs_o     = TUSE_0;
        tuse_rt_o     = TUSE_0;
      end
      OP_J: ctrl_o.npc_op = NPC_J;
      OP_JAL: begin
        ctrl_o.npc_op    = NPC_J;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.wd_sel    = WD_PC8;
        a3_o             = 5'd31;
        tnew_o           = TNEW_0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control and hazard unit: D-stage decode, E/M/W control registers,
// Tuse/Tnew stall and forwarding selects, and the MDU busy window.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  output logic        stall,
  output logic [1:0]  npc_op_d,
  output logic        ext_op_d,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [2:0]  alu_ctrl_e,
  output logic        alub_sel_e,
  output logic [2:0]  md_op_e,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        mem_write_m,
  output logic        mem_read_m,
  output logic        fwd_rt_m,
  output logic        reg_write_w,
  output logic [4:0]  grf_a3_w,
  output logic [1:0]  grf_wd_sel_w,
  output logic        md_busy
);

  localparam int unsigned MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW     = $clog2(MD_MAX + 1);

  ctrl_t      dec_ctrl;
  logic [4:0] dec_a3;
  time_t      dec_tnew;
  time_t      tuse_rs;
  time_t      tuse_rt;
  logic [4:0] rs_d;
  logic [4:0] rt_d;

  stage_t de_q, de_d;
  stage_t em_q, em_d;
  stage_t mw_q, mw_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  logic stall_data;
  logic stall_md;
  logic unused_mw_bits;

  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];

  instr_dec u_dec (
    .instr_i   (instr_d),
    .ctrl_o    (dec_ctrl),
    .a3_o      (dec_a3),
    .tnew_o    (dec_tnew),
    .tuse_rs_o (tuse_rs),
    .tuse_rt_o (tuse_rt)
  );

  // Only E and M can still be producing; W results are always forwardable.
  assign stall_data =
      (writes_src(de_q, rs_d) && (tuse_rs < de_q.tnew)) ||
      (writes_src(em_q, rs_d) && (tuse_rs < em_q.tnew)) ||
      (writes_src(de_q, rt_d) && (tuse_rt < de_q.tnew)) ||
      (writes_src(em_q, rt_d) && (tuse_rt < em_q.tnew));
  assign stall_md = dec_ctrl.md_use && (md_busy || (de_q.ctrl.md_op != MD_NONE));
  assign stall    = stall_data || stall_md;

  always_comb begin
    fwd_rs_d = FWD_GRF;
    if      (fwd_ready(de_q, rs_d)) fwd_rs_d = FWD_E;
    else if (fwd_ready(em_q, rs_d)) fwd_rs_d = FWD_M;
    else if (fwd_ready(mw_q, rs_d)) fwd_rs_d = FWD_W;

    fwd_rt_d = FWD_GRF;
    if      (fwd_ready(de_q, rt_d)) fwd_rt_d = FWD_E;
    else if (fwd_ready(em_q, rt_d)) fwd_rt_d = FWD_M;
    else if (fwd_ready(mw_q, rt_d)) fwd_rt_d = FWD_W;

    fwd_rs_e = FWD_GRF;
    if      (fwd_ready(em_q, de_q.rs)) fwd_rs_e = FWD_M;
    else if (fwd_ready(mw_q, de_q.rs)) fwd_rs_e = FWD_W;

    fwd_rt_e = FWD_GRF;
    if      (fwd_ready(em_q, de_q.rt)) fwd_rt_e = FWD_M;
    else if (fwd_ready(mw_q, de_q.rt)) fwd_rt_e = FWD_W;

    fwd_rt_m = fwd_ready(mw_q, em_q.rt);
  end

  always_comb begin
    de_d = STAGE_NOP;
    if (!stall) begin
      de_d.ctrl = dec_ctrl;
      de_d.rs   = rs_d;
      de_d.rt   = rt_d;
      de_d.a3   = dec_a3;
      de_d.tnew = dec_tnew;
    end
    em_d      = de_q;
    em_d.tnew = sat_dec(de_q.tnew);
    mw_d      = em_q;
    mw_d.tnew = sat_dec(em_q.tnew);

    md_cnt_d = md_cnt_q;
    case (de_q.ctrl.md_op)
      MD_MULT, MD_MULTU: md_cnt_d = CW'(MULT_CYCLES);
      MD_DIV, MD_DIVU:   md_cnt_d = CW'(DIV_CYCLES);
      default: if (md_cnt_q != '0) md_cnt_d = md_cnt_q - CW'(1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q     <= STAGE_NOP;
      em_q     <= STAGE_NOP;
      mw_q     <= STAGE_NOP;
      md_cnt_q <= '0;
    end else begin
      de_q     <= de_d;
      em_q     <= em_d;
      mw_q     <= mw_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign npc_op_d     = dec_ctrl.npc_op;
  assign ext_op_d     = dec_ctrl.ext_op;
  assign alu_ctrl_e   = de_q.ctrl.alu_ctrl;
  assign alub_sel_e   = de_q.ctrl.alub_sel;
  assign md_op_e      = de_q.ctrl.md_op;
  assign mem_write_m  = em_q.ctrl.mem_write;
  assign mem_read_m   = em_q.ctrl.mem_read;
  assign reg_write_w  = mw_q.ctrl.reg_write;
  assign grf_a3_w     = mw_q.a3;
  assign grf_wd_sel_w = mw_q.ctrl.wd_sel;
  assign md_busy      = (md_cnt_q != '0);

  // W keeps the whole bundle for uniformity; only a few fields leave the block.
  assign unused_mw_bits = ^mw_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each driven cycle queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        stall, ext_op_d, alub_sel_e, mem_write_m, mem_read_m, fwd_rt_m;
  logic        reg_write_w, md_busy;
  logic [1:0]  npc_op_d, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, grf_wd_sel_w;
  logic [2:0]  alu_ctrl_e, md_op_e;
  logic [4:0]  grf_a3_w;

  always #5 clk = ~clk;

  pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall),
    .npc_op_d(npc_op_d), .ext_op_d(ext_op_d), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .alu_ctrl_e(alu_ctrl_e), .alub_sel_e(alub_sel_e), .md_op_e(md_op_e),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .mem_write_m(mem_write_m),
    .mem_read_m(mem_read_m), .fwd_rt_m(fwd_rt_m), .reg_write_w(reg_write_w),
    .grf_a3_w(grf_a3_w), .grf_wd_sel_w(grf_wd_sel_w), .md_busy(md_busy)
  );

  typedef enum int {
    S_STALL, S_NPC, S_EXT, S_FRSD, S_FRTD, S_ALU, S_ALUB, S_MDOP, S_FRSE, S_FRTE,
    S_MW, S_MR, S_FRTM, S_RW, S_A3, S_WDSEL, S_BUSY
  } sig_t;

  typedef struct {
    int         cyc;
    sig_t       s;
    logic [7:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [7:0] probe(input sig_t s);
    case (s)
      S_STALL: return 8'(stall);
      S_NPC:   return 8'(npc_op_d);
      S_EXT:   return 8'(ext_op_d);
      S_FRSD:  return 8'(fwd_rs_d);
      S_FRTD:  return 8'(fwd_rt_d);
      S_ALU:   return 8'(alu_ctrl_e);
      S_ALUB:  return 8'(alub_sel_e);
      S_MDOP:  return 8'(md_op_e);
      S_FRSE:  return 8'(fwd_rs_e);
      S_FRTE:  return 8'(fwd_rt_e);
      S_MW:    return 8'(mem_write_m);
      S_MR:    return 8'(mem_read_m);
      S_FRTM:  return 8'(fwd_rt_m);
      S_RW:    return 8'(reg_write_w);
      S_A3:    return 8'(grf_a3_w);
      S_WDSEL: return 8'(grf_wd_sel_w);
      default: return 8'(md_busy);
    endcase
  endfunction

  task automatic chk(input string nm, input sig_t s, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc;
    e.s   = s;
    e.v   = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic [31:0] ins);
    @(posedge clk);
    #1;
    cyc++;
    instr_d = ins;
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      cur = q.pop_front();
      checks++;
      if (probe(cur.s) !== cur.v) begin
        errors++;
        $display("FAIL %s cyc %0d got %0h want %0h", cur.nm, cur.cyc, probe(cur.s), cur.v);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    instr_d = NOP;

    // reset state
    step(NOP);
    chk("rst_stall", S_STALL, 0); chk("rst_alub", S_ALUB, 0); chk("rst_mdop", S_MDOP, 0);
    chk("rst_mr", S_MR, 0); chk("rst_rw", S_RW, 0); chk("rst_a3", S_A3, 0);
    chk("rst_busy", S_BUSY, 0);

    // lw $1 ; addu $2,$1,$1
    step(i_ins(6'h23, 0, 1, 0)); reset = 1'b0;
    chk("a0_stall", S_STALL, 0); chk("a0_ext", S_EXT, 1);
    step(r_ins(1, 1, 2, 6'h21));
    chk("a1_stall", S_STALL, 1); chk("a1_alub", S_ALUB, 1); chk("a1_frsd", S_FRSD, 0);
    step(r_ins(1, 1, 2, 6'h21));
    chk("a2_stall", S_STALL, 0); chk("a2_mr", S_MR, 1); chk("a2_alub", S_ALUB, 0);
    step(NOP);
    chk("a3_frse", S_FRSE, 3); chk("a3_frte", S_FRTE, 3); chk("a3_rw", S_RW, 1);
    chk("a3_a3", S_A3, 1); chk("a3_wd", S_WDSEL, 1); chk("a3_alu", S_ALU, 0);
    step(NOP);
    step(NOP);
    chk("a5_rw", S_RW, 1); chk("a5_a3", S_A3, 2); chk("a5_wd", S_WDSEL, 0);
    step(NOP);

    // lw $1 ; beq $1,$1
    step(i_ins(6'h23, 0, 1, 0));
    step(i_ins(6'h04, 1, 1, 16'h0004));
    chk("b1_stall", S_STALL, 1); chk("b1_npc", S_NPC, 1); chk("b1_ext", S_EXT, 1);
    step(i_ins(6'h04, 1, 1, 16'h0004));
    chk("b2_stall", S_STALL, 1); chk("b2_frsd", S_FRSD, 0);
    step(i_ins(6'h04, 1, 1, 16'h0004));
    chk("b3_stall", S_STALL, 0); chk("b3_frsd", S_FRSD, 3); chk("b3_frtd", S_FRTD, 3);
    step(NOP); step(NOP); step(NOP);

    // ori $3,$0,5 ; sw $3,0($0)
    step(i_ins(6'h0d, 0, 3, 16'h0005));
    chk("c0_ext", S_EXT, 0); chk("c0_stall", S_STALL, 0);
    step(i_ins(6'h2b, 0, 3, 0));
    chk("c1_stall", S_STALL, 0); chk("c1_ext", S_EXT, 1); chk("c1_alu", S_ALU, 2);
    chk("c1_alub", S_ALUB, 1); chk("c1_frtd", S_FRTD, 0);
    step(NOP);
    chk("c2_frte", S_FRTE, 2); chk("c2_frse", S_FRSE, 0); chk("c2_alu", S_ALU, 0);
    step(NOP);
    chk("c3_mw", S_MW, 1); chk("c3_frtm", S_FRTM, 1); chk("c3_a3", S_A3, 3);
    step(NOP);
    chk("c4_mw", S_MW, 0); chk("c4_rw", S_RW, 0);
    step(NOP);

    // jal ; jr $31
    step({6'h03, 26'h0000100});
    chk("d0_npc", S_NPC, 2); chk("d0_stall", S_STALL, 0);
    step(r_ins(31, 0, 0, 6'h08));
    chk("d1_stall", S_STALL, 0); chk("d1_frsd", S_FRSD, 1); chk("d1_npc", S_NPC, 3);
    step(NOP);
    chk("d2_frse", S_FRSE, 2);
    step(NOP);
    chk("d3_rw", S_RW, 1); chk("d3_a3", S_A3, 31); chk("d3_wd", S_WDSEL, 2);
    step(NOP);

    // ori $3,1 ; ori $3,2 ; addu $4,$3,$0 : nearest ready producer wins
    step(i_ins(6'h0d, 0, 3, 16'h0001));
    step(i_ins(6'h0d, 0, 3, 16'h0002));
    step(r_ins(3, 0, 4, 6'h21));
    chk("h2_stall", S_STALL, 0); chk("h2_frsd", S_FRSD, 2); chk("h2_frtd", S_FRTD, 0);
    step(NOP);
    chk("h3_frse", S_FRSE, 2); chk("h3_frte", S_FRTE, 0);
    step(NOP); step(NOP); step(NOP);

    // writes to $0 never stall or forward; unknown opcode decodes as nop
    step(i_ins(6'h23, 0, 0, 0));
    step(r_ins(0, 0, 5, 6'h21));
    chk("g1_stall", S_STALL, 0); chk("g1_frsd", S_FRSD, 0); chk("g1_frtd", S_FRTD, 0);
    step(32'hfc00_0000);
    chk("g2_npc", S_NPC, 0); chk("g2_ext", S_EXT, 0); chk("g2_stall", S_STALL, 0);
    chk("g2_frse", S_FRSE, 0);
    step(NOP);
    chk("g3_alub", S_ALUB, 0); chk("g3_alu", S_ALU, 0);
    step(NOP); step(NOP);

    // mult $4,$5 ; mflo $6
    step(r_ins(4, 5, 0, 6'h18));
    chk("e0_stall", S_STALL, 0); chk("e0_busy", S_BUSY, 0);
    step(r_ins(0, 0, 6, 6'h12));
    chk("e1_stall", S_STALL, 1); chk("e1_busy", S_BUSY, 0); chk("e1_mdop", S_MDOP, 1);
    for (int unsigned i = 2; i <= 6; i++) begin
      step(r_ins(0, 0, 6, 6'h12));
      chk($sformatf("e%0d_stall", i), S_STALL, 1);
      chk($sformatf("e%0d_busy", i), S_BUSY, 1);
    end
    step(r_ins(0, 0, 6, 6'h12));
    chk("e7_stall", S_STALL, 0); chk("e7_busy", S_BUSY, 0); chk("e7_mdop", S_MDOP, 0);
    step(NOP); step(NOP); step(NOP);
    chk("e10_rw", S_RW, 1); chk("e10_a3", S_A3, 6); chk("e10_wd", S_WDSEL, 3);

    // div in flight, asynchronous reset mid-count, then mfhi
    step(r_ins(4, 5, 0, 6'h1a));
    step(NOP);
    chk("f1_mdop", S_MDOP, 3);
    step(i_ins(6'h23, 0, 1, 0));
    chk("f2_busy", S_BUSY, 1);
    step(i_ins(6'h0d, 0, 3, 16'h0005));
    chk("f3_busy", S_BUSY, 1); chk("f3_alub", S_ALUB, 1);
    step(NOP);
    #1 reset = 1'b1;
    chk("f4_busy", S_BUSY, 0); chk("f4_alub", S_ALUB, 0); chk("f4_alu", S_ALU, 0);
    chk("f4_mr", S_MR, 0); chk("f4_rw", S_RW, 0); chk("f4_stall", S_STALL, 0);
    step(r_ins(0, 0, 7, 6'h10)); reset = 1'b0;
    chk("f5_stall", S_STALL, 0); chk("f5_busy", S_BUSY, 0); chk("f5_mdop", S_MDOP, 0);
    step(NOP); step(NOP); step(NOP);
    chk("f8_rw", S_RW, 1); chk("f8_a3", S_A3, 7); chk("f8_wd", S_WDSEL, 3);

    step(NOP);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
